// File: rtl/grant_burst_mux.sv
// grant_burst_mux: moves a granted requester's burst onto one registered valid/ready channel
module grant_burst_mux #(
    parameter int DATA_W = 8,
    parameter int LEN_W  = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [2:0]        gnt_0,
    input  logic [2:0]        gnt_1,
    input  logic [DATA_W-1:0] s0_data,
    input  logic              s0_valid,
    output logic              s0_ready,
    input  logic [LEN_W-1:0]  s0_len,
    output logic              s0_done,
    input  logic [DATA_W-1:0] s1_data,
    input  logic              s1_valid,
    output logic              s1_ready,
    input  logic [LEN_W-1:0]  s1_len,
    output logic              s1_done,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_src,
    output logic              m_last,
    output logic              busy,
    output logic              err_both,
    output logic              abort
);
    typedef enum logic [1:0] {IDLE, XFER, DRAIN, DONE} state_t;
    localparam logic [LEN_W:0] ONE = 1;
    state_t            state_q, state_d;
    logic              sel_q, sel_d;
    logic [LEN_W:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0] m_data_q, m_data_d;
    logic              m_valid_q, m_valid_d;
    logic              m_src_q, m_src_d;
    logic              m_last_q, m_last_d;
    logic              s0_done_q, s0_done_d;
    logic              s1_done_q, s1_done_d;
    logic              err_both_q, err_both_d;
    logic              abort_q, abort_d;
    logic              gnt_sel, s_valid, rdy, acc;
    logic [DATA_W-1:0] s_data;
    logic [LEN_W-1:0]  s_len;
    logic              unused_gnt;
    assign unused_gnt = ^{gnt_0[2:1], gnt_1[2:1]};
    // Burst sequencing and output-register next values; a beat is loaded only when the output slot frees
    always_comb begin
        gnt_sel    = sel_q ? gnt_1[0] : gnt_0[0];
        s_valid    = sel_q ? s1_valid : s0_valid;
        s_data     = sel_q ? s1_data : s0_data;
        s_len      = gnt_1[0] ? s1_len : s0_len;
        rdy        = state_q == XFER && gnt_sel && cnt_q != '0 && (!m_valid_q || m_ready);
        acc        = rdy && s_valid;
        state_d    = state_q;
        sel_d      = sel_q;
        cnt_d      = acc ? cnt_q - ONE : cnt_q;
        m_data_d   = acc ? s_data : m_data_q;
        m_src_d    = acc ? sel_q : m_src_q;
        m_valid_d  = acc || (m_valid_q && !m_ready);
        m_last_d   = acc ? cnt_q == ONE : m_last_q && !m_ready;
        s0_done_d  = 1'b0;
        s1_done_d  = 1'b0;
        err_both_d = 1'b0;
        abort_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (gnt_0[0] && gnt_1[0]) begin
                    err_both_d = 1'b1;
                end else if (gnt_0[0] || gnt_1[0]) begin
                    sel_d   = gnt_1[0];
                    cnt_d   = {s_len == '0, s_len};
                    state_d = XFER;
                end
            end
            XFER: begin
                if (!gnt_sel) begin
                    abort_d = !m_valid_q;
                    state_d = m_valid_q ? XFER : IDLE;
                end else if (acc && cnt_q == ONE) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (m_ready) begin
                    s0_done_d = !sel_q;
                    s1_done_d = sel_q;
                    state_d   = DONE;
                end
            end
            DONE: state_d = gnt_sel ? DONE : IDLE;
        endcase
    end
    // State and registered outputs; reset drops any held beat silently
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            sel_q      <= 1'b0;
            cnt_q      <= '0;
            m_data_q   <= '0;
            m_valid_q  <= 1'b0;
            m_src_q    <= 1'b0;
            m_last_q   <= 1'b0;
            s0_done_q  <= 1'b0;
            s1_done_q  <= 1'b0;
            err_both_q <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            cnt_q      <= cnt_d;
            m_data_q   <= m_data_d;
            m_valid_q  <= m_valid_d;
            m_src_q    <= m_src_d;
            m_last_q   <= m_last_d;
            s0_done_q  <= s0_done_d;
            s1_done_q  <= s1_done_d;
            err_both_q <= err_both_d;
            abort_q    <= abort_d;
        end
    end
    assign s0_ready = rdy && !sel_q;
    assign s1_ready = rdy && sel_q;
    assign s0_done  = s0_done_q;
    assign s1_done  = s1_done_q;
    assign m_data   = m_data_q;
    assign m_valid  = m_valid_q;
    assign m_src    = m_src_q;
    assign m_last   = m_last_q;
    assign busy     = state_q != IDLE;
    assign err_both = err_both_q;
    assign abort    = abort_q;
endmodule

// File: tb/tb_grant_burst_mux.sv
// tb_grant_burst_mux: directed bench for grant_burst_mux
module tb_grant_burst_mux;
    logic       clock = 0, reset = 1;
    logic [2:0] gnt_0 = 0, gnt_1 = 0;
    logic [7:0] s0_data = 8'h10, s1_data = 8'hA0, m_data;
    logic       s0_valid = 0, s1_valid = 0, s0_ready, s1_ready, s0_done, s1_done;
    logic [3:0] s0_len = 0, s1_len = 0;
    logic       m_valid, m_ready = 0, m_src, m_last, busy, err_both, abort;
    int total = 0, bad = 0, cyc = 0, t0;
    int n_done0, n_done1, n_abort, n_err, n_rdy0, n_rdy1, n_busy, stall_bad;
    int s0_idx, s1_idx, hval;
    bit tog = 0, hold = 0;
    int beats[$];
    int bcyc[$];

    always #5 clock = ~clock;

    grant_burst_mux dut (
        .clock(clock), .reset(reset), .gnt_0(gnt_0), .gnt_1(gnt_1),
        .s0_data(s0_data), .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_len(s0_len), .s0_done(s0_done),
        .s1_data(s1_data), .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_len(s1_len), .s1_done(s1_done),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_src(m_src), .m_last(m_last),
        .busy(busy), .err_both(err_both), .abort(abort)
    );

    function automatic int bt(input logic s, input logic l, input logic [7:0] d);
        return int'({s, l, d});
    endfunction

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic clr();
        n_done0 = 0; n_done1 = 0; n_abort = 0; n_err = 0;
        n_rdy0 = 0; n_rdy1 = 0; n_busy = 0; stall_bad = 0;
        s0_idx = 0; s1_idx = 0; s0_data = 8'h10; s1_data = 8'hA0;
        beats.delete(); bcyc.delete();
    endtask

    task automatic step();
        logic a0, a1;
        @(negedge clock);
        cyc++;
        if (m_valid && m_ready) begin
            beats.push_back(bt(m_src, m_last, m_data));
            bcyc.push_back(cyc);
        end
        if (hold && (!m_valid || bt(m_src, m_last, m_data) != hval)) stall_bad++;
        hold = !reset && m_valid && !m_ready;
        hval = bt(m_src, m_last, m_data);
        a0 = s0_valid && s0_ready;
        a1 = s1_valid && s1_ready;
        n_done0 += int'(s0_done); n_done1 += int'(s1_done);
        n_abort += int'(abort);   n_err   += int'(err_both);
        n_rdy0  += int'(s0_ready); n_rdy1 += int'(s1_ready);
        n_busy  += int'(busy);
        @(posedge clock);
        #1;
        if (a0) s0_idx++;
        if (a1) s1_idx++;
        s0_data = 8'h10 + 8'(s0_idx);
        s1_data = 8'hA0 + 8'(s1_idx);
        if (tog) m_ready = !m_ready;
    endtask

    task automatic stepn(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        clr();
        stepn(2);
        chk("rst_mvalid", int'(m_valid), 0);
        chk("rst_mdata", int'(m_data), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_rdy", int'({s0_ready, s1_ready}), 0);
        chk("rst_pulses", int'({s0_done, s1_done, err_both, abort}), 0);
        reset = 0;
        step();

        // 1: s0 burst of 3 at full rate
        clr();
        gnt_0 = 3'b111; s0_len = 3; s0_valid = 1; m_ready = 1;
        t0 = cyc;
        stepn(6);
        chk("t1_n", beats.size(), 3);
        chk("t1_b0", beats[0], bt(0, 0, 8'h10));
        chk("t1_b1", beats[1], bt(0, 0, 8'h11));
        chk("t1_b2", beats[2], bt(0, 1, 8'h12));
        chk("t1_lat", bcyc[0], t0 + 3);
        chk("t1_gap1", bcyc[1] - bcyc[0], 1);
        chk("t1_gap2", bcyc[2] - bcyc[1], 1);
        chk("t1_busy_held", int'(busy), 1);
        gnt_0 = 3'b110;
        stepn(2);
        chk("t1_done", n_done0, 1);
        chk("t1_busy", int'(busy), 0);
        s0_valid = 0;

        // 2: s1 burst len=0 (16 beats) under toggling backpressure
        clr();
        gnt_1 = 3'b011; s1_len = 0; s1_valid = 1; m_ready = 1; tog = 1;
        stepn(50);
        chk("t2_n", beats.size(), 16);
        for (int i = 0; i < 16; i++)
            chk($sformatf("t2_b%0d", i), beats[i], bt(1, i == 15, 8'hA0 + 8'(i)));
        chk("t2_stall", stall_bad, 0);
        chk("t2_done1", n_done1, 1);
        chk("t2_done0", n_done0, 0);
        gnt_1 = 0; tog = 0; m_ready = 1; s1_valid = 0;
        stepn(2);
        chk("t2_busy", int'(busy), 0);

        // 3: both grants in IDLE
        clr();
        gnt_0 = 3'b001; gnt_1 = 3'b001; s0_valid = 1; s1_valid = 1;
        step();
        gnt_0 = 0; gnt_1 = 0;
        stepn(3);
        chk("t3_err", n_err, 1);
        chk("t3_rdy", n_rdy0 + n_rdy1, 0);
        chk("t3_busy", n_busy, 0);
        s0_valid = 0; s1_valid = 0;

        // 4: grant drop mid-burst with a held beat
        clr();
        gnt_1 = 3'b001; s1_len = 4; s1_valid = 1; m_ready = 1;
        stepn(3);
        m_ready = 0; gnt_1 = 3'b110;
        stepn(3);
        chk("t4_abort_early", n_abort, 0);
        chk("t4_held", bt(m_src, m_last, m_data) | (int'(m_valid) << 12), bt(1, 0, 8'hA1) | (1 << 12));
        m_ready = 1;
        stepn(4);
        chk("t4_n", beats.size(), 2);
        chk("t4_b0", beats[0], bt(1, 0, 8'hA0));
        chk("t4_b1", beats[1], bt(1, 0, 8'hA1));
        chk("t4_acc", s1_idx, 2);
        chk("t4_abort", n_abort, 1);
        chk("t4_done", n_done1, 0);
        chk("t4_stall", stall_bad, 0);
        chk("t4_busy", int'(busy), 0);
        gnt_1 = 0; s1_valid = 0;

        // 5: reset mid-burst, then a clean burst of 2
        clr();
        gnt_0 = 3'b001; s0_len = 5; s0_valid = 1; m_ready = 0;
        stepn(3);
        chk("t5_pre", int'(m_valid), 1);
        reset = 1; gnt_0 = 0;
        step();
        chk("t5_outs", int'({m_valid, m_data, m_src, m_last, busy}), 0);
        chk("t5_ctl", int'({s0_ready, s1_ready, s0_done, s1_done, err_both, abort}), 0);
        reset = 0;
        clr();
        gnt_0 = 3'b001; s0_len = 2; m_ready = 1;
        stepn(7);
        chk("t5_n", beats.size(), 2);
        chk("t5_b0", beats[0], bt(0, 0, 8'h10));
        chk("t5_b1", beats[1], bt(0, 1, 8'h11));
        chk("t5_done", n_done0, 1);
        chk("t5_abort", n_abort, 0);
        gnt_0 = 0;
        stepn(2);

        // 6: competing grant ignored until IDLE
        clr();
        gnt_0 = 3'b001; s0_len = 3; s0_valid = 1; s1_valid = 1; s1_len = 2; m_ready = 1;
        stepn(2);
        gnt_1 = 3'b101;
        stepn(6);
        chk("t6_rdy1", n_rdy1, 0);
        chk("t6_n0", beats.size(), 3);
        chk("t6_done0", n_done0, 1);
        gnt_0 = 0;
        stepn(8);
        chk("t6_n", beats.size(), 5);
        chk("t6_b2", beats[2], bt(0, 1, 8'h12));
        chk("t6_b3", beats[3], bt(1, 0, 8'hA0));
        chk("t6_b4", beats[4], bt(1, 1, 8'hA1));
        chk("t6_done1", n_done1, 1);
        chk("t6_err", n_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
